// File: rtl/ifu_fetch.sv
// ifu_fetch: single-issue instruction fetch unit.
// Holds the PC, issues one memory read per instruction, hands the returned word
// to decode over a valid/ready handshake, then waits for execute to supply the
// next PC before fetching again.
// Optional build macro: IFU_MISALIGN_CHECK_EN
//   defined   -> a PC with nonzero low two bits is not requested from memory;
//                a faulted, zeroed instruction goes straight to decode instead.
//   undefined -> the full PC is sent to memory unchanged.
`timescale 1ns/1ps

module ifu_fetch #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'(32'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [ISA_WIDTH-1:0] req_addr,
  input  logic                 resp_valid,
  input  logic [ISA_WIDTH-1:0] resp_data,
  input  logic                 resp_err,
  output logic [ISA_WIDTH-1:0] inst,
  output logic [ISA_WIDTH-1:0] inst_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic                 inst_fault,
  input  logic                 npc_valid,
  input  logic [ISA_WIDTH-1:0] npc
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_RESP = 2'd1,
    HOLD      = 2'd2,
    WAIT_NPC  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ISA_WIDTH-1:0] pc_q, pc_d;
  logic [ISA_WIDTH-1:0] inst_q, inst_d;
  logic [ISA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                 inst_fault_q, inst_fault_d;
  logic                 misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Request is gated by rst so nothing is issued while reset is still held.
  assign req_valid  = (state_q == FETCH) && !misaligned && !rst;
  assign req_addr   = pc_q;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  // Next-state and datapath selection; every register holds unless a transition fires.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    case (state_q)
      FETCH: begin
        if (misaligned) begin
          state_d      = HOLD;
          inst_d       = '0;
          inst_fault_d = 1'b1;
          inst_pc_d    = pc_q;
        end else if (req_ready) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          state_d      = HOLD;
          inst_d       = resp_err ? '0 : resp_data;
          inst_fault_d = resp_err;
          inst_pc_d    = pc_q;
        end
      end
      HOLD: begin
        // npc_valid here is deliberately ignored; decode must accept first.
        if (inst_ready) begin
          state_d = WAIT_NPC;
        end
      end
      WAIT_NPC: begin
        if (npc_valid) begin
          pc_d    = npc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with synchronous reset; a response in flight at reset is
  // dropped naturally because it lands in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

endmodule
